// File: rtl/gpio_pkg.sv
// Shared register offsets and default sizing for the GPIO edge-capture block.
package gpio_pkg;

    localparam logic [1:0] GPIO_LEVEL   = 2'd0;
    localparam logic [1:0] GPIO_PENDING = 2'd1;
    localparam logic [1:0] GPIO_RISE_EN = 2'd2;
    localparam logic [1:0] GPIO_FALL_EN = 2'd3;

    localparam int GPIO_NUM_PINS_DEF   = 13;
    localparam int GPIO_DEBOUNCE_DEF   = 4;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: 2-flop synchroniser, debounce counter and accepted level.
// Edge pulses are combinational and high in the cycle whose closing edge flips the level.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF,
    parameter int CNT_W           = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_flip;

    assign w_diff = r_s2 ^ r_level;
    assign w_flip = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
            // Any sample agreeing with the accepted level restarts qualification.
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level      = r_level;
    assign o_rise_pulse = w_flip & r_s2;
    assign o_fall_pulse = w_flip & ~r_s2;

endmodule

// File: rtl/gpio_edge_capture.sv
// GPIO input conditioning with sticky edge capture, level irq and a tri-state register port.
// Reads are combinational onto data_bus; writes, W1C and edge capture update on the clock edge.
module gpio_edge_capture
    import gpio_pkg::*;
#(
    parameter int NUM_PINS        = GPIO_NUM_PINS_DEF,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF,
    parameter int CNT_W           = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_PINS-1:0] pin_in,
    input  logic                CS,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          addr,
    inout  wire  [63:0]         data_bus,
    output logic                irq
);

    logic [NUM_PINS-1:0] w_level;
    logic [NUM_PINS-1:0] w_rise;
    logic [NUM_PINS-1:0] w_fall;
    logic [NUM_PINS-1:0] w_set;
    logic [NUM_PINS-1:0] w_clr;
    logic [NUM_PINS-1:0] w_wr_dat;
    logic [63:0]         w_rd_dat;
    logic                w_wr;
    logic                w_rd;

    logic [NUM_PINS-1:0] r_rise_en;
    logic [NUM_PINS-1:0] r_fall_en;
    logic [NUM_PINS-1:0] r_pending;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clock        (clock),
            .reset        (reset),
            .i_pin        (pin_in[i]),
            .o_level      (w_level[i]),
            .o_rise_pulse (w_rise[i]),
            .o_fall_pulse (w_fall[i])
        );
    end

    assign w_wr     = CS & mem_write & ~mem_read;
    assign w_rd     = CS & mem_read & ~mem_write;
    assign w_wr_dat = data_bus[NUM_PINS-1:0];

    // Masks are sampled before any same-edge write lands, so a coincident flip sees the old mask.
    assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr = (w_wr && addr == GPIO_PENDING) ? w_wr_dat : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_pending <= '0;
        end else begin
            if (w_wr && addr == GPIO_RISE_EN) r_rise_en <= w_wr_dat;
            if (w_wr && addr == GPIO_FALL_EN) r_fall_en <= w_wr_dat;
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_rd_dat = '0;
        case (addr)
            GPIO_LEVEL:   w_rd_dat[NUM_PINS-1:0] = w_level;
            GPIO_PENDING: w_rd_dat[NUM_PINS-1:0] = r_pending;
            GPIO_RISE_EN: w_rd_dat[NUM_PINS-1:0] = r_rise_en;
            GPIO_FALL_EN: w_rd_dat[NUM_PINS-1:0] = r_fall_en;
        endcase
    end

    assign data_bus = w_rd ? w_rd_dat : {64{1'bz}};
    assign irq      = |r_pending;

endmodule

// File: doc/gpio_edge_capture.md
Name: gpio_edge_capture

Overview:
- Input-conditioning and event-capture stage for the 13 GPIO pins; sits upstream of the per-pin peripheral read path on the shared 64-bit data bus.
- Each pin is synchronised, debounced and edge-detected.
- Enabled rising/falling edges latch into a sticky pending register and raise a level interrupt.
- Software reads levels and pending bits, programs the edge masks, and clears pending bits, all through the CS/mem_read/mem_write bus protocol.

Parameters:
- NUM_PINS, 13, number of GPIO inputs handled (1..64).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from the accepted level before the level flips (2..255).
- CNT_W, 8, width of the per-pin debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pin_in  input  NUM_PINS  raw asynchronous pin levels.
- CS  input  1  block select from the address decoder.
- mem_read  input  1  bus read strobe.
- mem_write  input  1  bus write strobe.
- addr  input  2  register offset within the block.
- data_bus  inout  64  shared bus.
  - Driven only during a valid read; high-Z otherwise.
  - Unused upper bits are driven 0 during a read.
- irq  output  1  high while any pending bit is set.

Behaviour:
- Clock and reset:
  - One clock: clock.
  - reset is asynchronous and active-high.
  - While reset is high, all flops clear to 0: sync stages, debounce counters, level, pending, rise_en, fall_en.
  - Consequently irq=0 during and after reset, and data_bus is high-Z unless a valid read is in progress.
- Synchroniser: two flops per pin, pin_in -> s1 -> s2. s2 reflects pin_in after 2 clock edges.
- Debounce, per pin, with counter cnt:
  - If s2 == level: cnt clears to 0.
  - If s2 != level and cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - If s2 != level and cnt == DEBOUNCE_CYCLES-1: level takes s2 and cnt clears to 0 on that same edge.
  - Latency: a clean change sampled at edge k appears on level at edge k+1+DEBOUNCE_CYCLES (k+5 at the default).
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes level.
- Edge event, per pin, asserted on the edge where level flips:
  - rise = flip to 1 AND rise_en[i].
  - fall = flip to 0 AND fall_en[i].
  - Any event sets pending[i] on that same edge.
- Register map (addr):
  - 0 LEVEL: read-only; writes are ignored.
  - 1 PENDING: read; write-1-to-clear.
  - 2 RISE_EN: read/write.
  - 3 FALL_EN: read/write.
- Write: occurs on a rising edge when CS & mem_write & ~mem_read. Uses data_bus[NUM_PINS-1:0]; upper bits are ignored.
- Read: data_bus = {zeros, reg[addr]} combinationally while CS & mem_read & ~mem_write; otherwise 64'bz.
- CS with both strobes high: no write and no drive.
- Simultaneous set and clear on the same pin in the same cycle: the set wins, so pending stays 1.
- Mask changes:
  - A write to RISE_EN/FALL_EN takes effect for flips on the following edge onwards.
  - A flip on the same edge as the mask write uses the old mask.
  - Clearing an enable does not clear pending bits already latched.
- irq = |pending, driven from registered state (no input-to-irq combinational path).
- Reset mid-debounce: the count and level are discarded. After release, a pin held high at reset release re-qualifies and produces a rising event if rise_en is set.

Decomposition:
- Shared package gpio_pkg holds:
  - register offset constants GPIO_LEVEL=0, GPIO_PENDING=1, GPIO_RISE_EN=2, GPIO_FALL_EN=3;
  - default NUM_PINS=13 and DEBOUNCE_CYCLES=4.
- Sub-module gpio_debounce_bit:
  - Contains the 2-flop sync, the counter, and the level flop.
  - Outputs level, rise_pulse and fall_pulse.
  - Instantiated NUM_PINS times via generate.
- The top level holds the mask and pending registers, the bus decode and the tri-state driver.

Test Plan:
- Reset and idle: reset pulsed with pin_in=13'h1FFF -> level, pending, masks, irq all 0 and data_bus=Z; after release with no writes, LEVEL reads 13'h1FFF from edge 6 onward.
- Rising edge, debounced: RISE_EN=13'h0001 written, pin_in[0] 0->1 before edge k -> level[0]=1 and pending[0]=1 at edge k+5; irq=1 from then; PENDING read returns 64'h1.
- Glitch reject: pin_in[3] high for 3 cycles then low, RISE_EN=FALL_EN=13'h1FFF -> LEVEL and PENDING stay 0 and irq stays 0.
- W1C and collision: pending=13'h0011; write 13'h0001 to PENDING -> reads 13'h0010. In the same cycle as a W1C of bit 4, a new fall event on pin 4 (FALL_EN[4]=1) -> pending[4] remains 1.
- Masking: RISE_EN=0, FALL_EN=13'h0004, pin 2 rises then falls -> pending[2] set only after the fall; LEVEL tracks both transitions.
- Bus hygiene: CS=0 with mem_read=1, or CS=1 with mem_read=mem_write=1 -> data_bus stays Z and no register changes; write to LEVEL -> LEVEL unchanged.
